// File: rtl/load_store_ctrl.sv
// Load/store controller between the execute/memory stage and a ready-handshake data memory port.
// It formats store lanes, extends load data, and reports misaligned, illegal-width and timed-out accesses.
module load_store_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  loadCtrl,
  input  logic [1:0]  storeCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] storeData,
  output logic        dmemReq,
  output logic        dmemWe,
  output logic [31:0] dmemAddr,
  output logic [3:0]  dmemByteEn,
  output logic [31:0] dmemWData,
  input  logic [31:0] dmemRData,
  input  logic        dmemReady,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        fault,
  output logic [1:0]  faultCause
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit TO_EN = (TIMEOUT != 0);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic             is_load_r;
  logic [2:0]       ld_funct_r;
  logic [1:0]       ld_off_r;

  logic        req_s, is_store_s, illegal_s, misalign_s;
  logic [3:0]  be_s;
  logic [31:0] wdata_s;
  logic        stall_s, accept_s, complete_s, timeout_s, bad_s;

  // Selects the byte or half named by the latched offset and sign/zero-extends it.
  function automatic logic [31:0] extend_load(input logic [2:0] funct,
                                              input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = rdata >> {off, 3'b000};
    b = shifted[7:0];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (funct)
      3'b000:  extend_load = {{24{b[7]}}, b};
      3'b001:  extend_load = {{16{h[15]}}, h};
      3'b100:  extend_load = {24'h000000, b};
      3'b101:  extend_load = {16'h0000, h};
      default: extend_load = rdata;
    endcase
  endfunction

  assign req_s      = memRead | memWrite;
  assign is_store_s = memWrite;
  assign stall      = stall_s & ~rst;

  // Request decode: legality, alignment, byte lanes and replicated write data.
  always_comb begin
    illegal_s  = 1'b0;
    misalign_s = 1'b0;
    be_s       = 4'b1111;
    wdata_s    = storeData;
    if (is_store_s) begin
      case (storeCtrl)
        2'b00: begin
          be_s    = 4'b0001 << addr[1:0];
          wdata_s = {4{storeData[7:0]}};
        end
        2'b01: begin
          be_s       = 4'b0011 << addr[1:0];
          wdata_s    = {2{storeData[15:0]}};
          misalign_s = addr[0];
        end
        2'b10:   misalign_s = (addr[1:0] != 2'b00);
        default: illegal_s  = 1'b1;
      endcase
    end else begin
      case (loadCtrl)
        3'b000, 3'b100: misalign_s = 1'b0;
        3'b001, 3'b101: misalign_s = addr[0];
        3'b010:         misalign_s = (addr[1:0] != 2'b00);
        default:        illegal_s  = 1'b1;
      endcase
    end
  end

  // Next-state logic and combinational pipeline hold.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    accept_s     = 1'b0;
    complete_s   = 1'b0;
    timeout_s    = 1'b0;
    bad_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          stall_s = 1'b1;
          if (illegal_s | misalign_s) begin
            bad_s        = 1'b1;
            state_next_s = FAULT;
          end else begin
            accept_s     = 1'b1;
            state_next_s = BUSY;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      BUSY: begin
        stall_s = 1'b1;
        // Ready wins over a timeout landing in the same cycle.
        if (dmemReady) begin
          complete_s   = 1'b1;
          state_next_s = DONE;
        end else if (TO_EN && (cnt_r == CNT_LAST)) begin
          timeout_s    = 1'b1;
          state_next_s = FAULT;
        end else begin
          state_next_s = BUSY;
        end
      end
      DONE:    state_next_s = IDLE;
      FAULT:   state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, timeout counter, latched access and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      is_load_r  <= 1'b0;
      ld_funct_r <= 3'b000;
      ld_off_r   <= 2'b00;
      dmemReq    <= 1'b0;
      dmemWe     <= 1'b0;
      dmemAddr   <= 32'h0000_0000;
      dmemByteEn <= 4'b0000;
      dmemWData  <= 32'h0000_0000;
      loadData   <= 32'h0000_0000;
      loadValid  <= 1'b0;
      fault      <= 1'b0;
      faultCause <= 2'b00;
    end else begin
      state_r   <= state_next_s;
      loadValid <= 1'b0;
      fault     <= 1'b0;
      if (accept_s) begin
        dmemReq    <= 1'b1;
        dmemWe     <= is_store_s;
        dmemAddr   <= {addr[31:2], 2'b00};
        dmemByteEn <= be_s;
        dmemWData  <= wdata_s;
        is_load_r  <= ~is_store_s;
        ld_funct_r <= loadCtrl;
        ld_off_r   <= addr[1:0];
        cnt_r      <= '0;
      end else if (complete_s) begin
        dmemReq <= 1'b0;
        dmemWe  <= 1'b0;
        if (is_load_r) begin
          loadData  <= extend_load(ld_funct_r, ld_off_r, dmemRData);
          loadValid <= 1'b1;
        end
      end else if (timeout_s) begin
        dmemReq    <= 1'b0;
        dmemWe     <= 1'b0;
        fault      <= 1'b1;
        faultCause <= 2'b10;
      end else if (bad_s) begin
        fault      <= 1'b1;
        faultCause <= illegal_s ? 2'b11 : 2'b01;
      end else if (state_r == BUSY) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

endmodule
